mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates the single-port unified instruction/data memory between the fetch stage (IF, driven by the PC) and the MEM stage (loads/stores from the EX/MEM segment register). It grants at most one access per cycle, returns read data one cycle later to the granted requester, and raises per-stage stall signals. The pipeline top uses these stalls to freeze the PC register and the segment registers. A bounded-wait counter keeps a continuous stream of data accesses from starving fetch.

## Interface
- ADDR_W, 32, address width in words
- DATA_W, 32, data width
- MAX_WAIT, 4, consecutive denied fetch cycles before fetch is forced to win (1..15)

- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-low reset
- if_req  in  1  fetch request
- if_addr  in  ADDR_W  fetch address (pc_out)
- if_grant  out  1  fetch granted this cycle
- if_valid  out  1  if_rdata holds a new instruction
- if_rdata  out  DATA_W  fetched instruction, held until the next if_valid
- d_req  in  1  data request
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address (alu_res_mem)
- d_wdata  in  DATA_W  store data (RD3_mem)
- d_grant  out  1  data access granted this cycle
- d_valid  out  1  d_rdata holds new load data
- d_rdata  out  DATA_W  load data, held until the next d_valid
- mem_addr  out  ADDR_W  memory address
- mem_we  out  1  memory write enable
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid one cycle after the address
- stall_if  out  1  if_req & ~if_grant
- stall_mem  out  1  d_req & ~d_grant

## Operation
- Arbitration is combinational each cycle:
  - force_if = if_req & (wait_cnt == MAX_WAIT).
  - d_grant = d_req & ~force_if & rst.
  - if_grant = if_req & ~d_grant & rst.
- Memory port drives from the granted requester. No grant: mem_addr = 0, mem_we = 0, mem_wdata = 0. mem_we = d_grant & d_we only.
- wait_cnt (4 bits, registered):
  - Increments when if_req & ~if_grant, saturating at MAX_WAIT.
  - Clears to 0 on if_grant or ~if_req.
- Response tracker FSM (registered owner of the in-flight read):
  - States: IDLE, IF_PEND, D_PEND.
  - Next state = IF_PEND if if_grant; else D_PEND if d_grant & ~d_we; else IDLE. Evaluated from any state, so back-to-back reads are allowed.
  - IF_PEND: if_valid = 1, if_rdata <= mem_rdata.
  - D_PEND: d_valid = 1, d_rdata <= mem_rdata.
  - IDLE: both valids 0, data registers hold.
- Stores produce no d_valid. A store is complete at the rising edge that ends its grant cycle.
- Reset values when rst = 0 at a rising edge:
  - State IDLE, wait_cnt 0, if_rdata 0, d_rdata 0.
  - if_valid and d_valid are 0 in the following cycle.
  - While rst = 0: all grants 0, mem_we 0, and stall_if/stall_mem follow the requests.
- Reset mid-operation: a read granted in the cycle before reset is discarded. No valid is issued after reset.

## Timing
- Grant latency: 0 cycles, same cycle as the request.
- Read latency: valid and data are presented one cycle after the grant cycle.
- Throughput: 1 access per cycle.
- Both requesters active:
  - Data wins while wait_cnt < MAX_WAIT.
  - Fetch wins in the cycle wait_cnt == MAX_WAIT. Data is stalled that cycle, and wait_cnt returns to 0.
- Requesters must hold req, addr, we and wdata stable while their stall output is high. The block does not check this.
- Sustained both-request load gives MAX_WAIT data grants followed by 1 fetch grant, repeating (period MAX_WAIT+1).
- A single requester is never stalled.

## Test plan
- Reset: hold rst = 0 for 2 cycles with if_req = d_req = 1. Required: grants 0, mem_we 0, stall_if = stall_mem = 1, valids 0, rdata 0; first cycle after release grants data (d_req priority).
- Fetch only: if_req = 1 with if_addr = 0, 1, 2 on consecutive cycles, memory returning addr+0x100. Required: if_grant = 1 every cycle; if_valid = 1 with if_rdata 0x100, 0x101, 0x102 on cycles 1–3.
- Load/store: store 0xDEADBEEF to addr 8, then load addr 8 on the next cycle. Required: mem_we = 1 only in the store cycle, no d_valid for the store, d_valid = 1 with d_rdata = 0xDEADBEEF one cycle after the load grant.
- Conflict: if_req = d_req = 1 for 10 cycles, loads, MAX_WAIT = 4. Required: d_grant pattern 1,1,1,1,0,1,1,1,1,0; stall_if high in data-grant cycles; stall_mem high in cycles 5 and 10.
- Hold behaviour: one fetch, then 3 idle cycles. Required: if_valid pulses once, if_rdata unchanged through the idle cycles, state returns to IDLE.
- Reset mid-read: load granted at cycle N, rst = 0 sampled at edge N+1. Required: d_valid = 0 and d_rdata = 0 after reset, wait_cnt = 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port unified memory between instruction fetch (IF) and
// the MEM stage. At most one access is granted per cycle; read data comes
// back one cycle after the grant and is returned to whoever owned the read.
// A bounded-wait counter forces a fetch grant after MAX_WAIT consecutive
// denied fetch cycles so a stream of data accesses cannot starve fetch.
//
// Ports
//   clk_i, rst_ni           clock (rising edge), synchronous active-low reset
//   if_req_i, if_addr_i     fetch request / address
//   if_grant_o              fetch granted this cycle
//   if_valid_o, if_rdata_o  instruction returned (data held until next valid)
//   d_req_i, d_we_i         data request, 1 = store / 0 = load
//   d_addr_i, d_wdata_i     data address / store data
//   d_grant_o               data access granted this cycle
//   d_valid_o, d_rdata_o    load data returned (data held until next valid)
//   mem_addr_o, mem_we_o, mem_wdata_o, mem_rdata_i   memory port
//   stall_if_o, stall_mem_o request pending but not granted
//   state_o                 debug: response tracker state (0 IDLE, 1 IF_PEND, 2 D_PEND)
//   wait_cnt_o              debug: consecutive denied fetch cycles
//
// Handshake: a requester raises req with addr/we/wdata; grant is combinational
// in the same cycle. An access completes at the rising edge ending its grant
// cycle. A requester whose stall is high must keep req/addr/we/wdata stable.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_grant_o,
  output logic              if_valid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_grant_o,
  output logic              d_valid_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_if_o,
  output logic              stall_mem_o,
  output logic [1:0]        state_o,
  output logic [3:0]        wait_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IF_PEND = 2'd1,
    ST_D_PEND  = 2'd2
  } state_e;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  state_e            state_q, state_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
  logic              force_if, if_grant, d_grant;

  always_comb begin
    // Arbitration: data has priority unless fetch has waited MAX_WAIT cycles.
    force_if = if_req_i && (wait_cnt_q == MAX_WAIT_C);
    d_grant  = d_req_i && !force_if && rst_ni;
    if_grant = if_req_i && !d_grant && rst_ni;

    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_wdata_o = '0;
    if (d_grant) begin
      mem_addr_o  = d_addr_i;
      mem_we_o    = d_we_i;
      mem_wdata_o = d_wdata_i;
    end else if (if_grant) begin
      mem_addr_o  = if_addr_i;
    end

    // Starvation counter: counts denied fetch cycles, saturating.
    wait_cnt_d = wait_cnt_q;
    if (!if_req_i || if_grant) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q != MAX_WAIT_C) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end

    // Owner of the read returning next cycle; re-evaluated every cycle so
    // back-to-back reads chain without an IDLE gap.
    state_d = ST_IDLE;
    if (if_grant) begin
      state_d = ST_IF_PEND;
    end else if (d_grant && !d_we_i) begin
      state_d = ST_D_PEND;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= 4'd0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (state_q == ST_IF_PEND) begin
        if_rdata_q <= mem_rdata_i;
      end
      if (state_q == ST_D_PEND) begin
        d_rdata_q <= mem_rdata_i;
      end
    end
  end

  assign if_grant_o  = if_grant;
  assign d_grant_o   = d_grant;
  assign if_valid_o  = (state_q == ST_IF_PEND);
  assign d_valid_o   = (state_q == ST_D_PEND);
  // Memory data is forwarded in the valid cycle and captured for holding.
  assign if_rdata_o  = (state_q == ST_IF_PEND) ? mem_rdata_i : if_rdata_q;
  assign d_rdata_o   = (state_q == ST_D_PEND) ? mem_rdata_i : d_rdata_q;
  assign stall_if_o  = if_req_i && !if_grant;
  assign stall_mem_o = d_req_i && !d_grant;
  assign state_o     = state_q;
  assign wait_cnt_o  = wait_cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic
// scored against a rule-level model with a shadow memory and response queue.
module tb_mem_port_arbiter;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_ni;
  logic              if_req, d_req, d_we;
  logic [ADDR_W-1:0] if_addr, d_addr;
  logic [DATA_W-1:0] d_wdata, mem_rdata;
  logic              if_grant_o, if_valid_o, d_grant_o, d_valid_o;
  logic [DATA_W-1:0] if_rdata_o, d_rdata_o, mem_wdata_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_we_o, stall_if_o, stall_mem_o;
  logic [1:0]        state_o;
  logic [3:0]        wait_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_grant_o(if_grant_o),
    .if_valid_o(if_valid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_grant_o(d_grant_o), .d_valid_o(d_valid_o), .d_rdata_o(d_rdata_o),
    .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata), .stall_if_o(stall_if_o), .stall_mem_o(stall_mem_o),
    .state_o(state_o), .wait_cnt_o(wait_cnt_o)
  );

  // 16-word synchronous memory: read data one cycle after the address.
  logic [DATA_W-1:0] mem [16];
  initial for (int i = 0; i < 16; i++) mem[i] = 32'h100 + i;
  always @(posedge clk) begin
    if (mem_we_o) mem[mem_addr_o[3:0]] <= mem_wdata_o;
    mem_rdata <= mem[mem_addr_o[3:0]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; if_req = 1'b1; d_req = 1'b1; d_we = 1'b1; d_addr = 32'd8; d_wdata = 32'h55;
    for (int k = 0; k < 2; k++) begin
      tick(); #1;
      n_tests++;
      if ({if_grant_o, d_grant_o, mem_we_o, stall_if_o, stall_mem_o, if_valid_o, d_valid_o} !== 7'b0001100) begin
        n_fail++;
        $display("FAIL reset_ctl: got %b expected %b", {if_grant_o, d_grant_o, mem_we_o, stall_if_o, stall_mem_o, if_valid_o, d_valid_o}, 7'b0001100);
      end
      n_tests++;
      if ({if_rdata_o, d_rdata_o, wait_cnt_o} !== '0) begin
        n_fail++;
        $display("FAIL reset_regs: got if_rdata=%h d_rdata=%h wait=%0d expected all 0", if_rdata_o, d_rdata_o, wait_cnt_o);
      end
    end
    rst_ni = 1'b1; d_we = 1'b0; d_addr = 32'd3; #1;
    n_tests++;
    if ({d_grant_o, if_grant_o, stall_if_o, stall_mem_o} !== 4'b1010) begin
      n_fail++;
      $display("FAIL reset_release_prio: got %b expected 1010", {d_grant_o, if_grant_o, stall_if_o, stall_mem_o});
    end
    tick(); idle_inputs(); #1;
    n_tests++;
    if (d_valid_o !== 1'b1 || d_rdata_o !== 32'h103 || if_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_load: got d_valid=%b d_rdata=%h if_valid=%b expected 1 00000103 0", d_valid_o, d_rdata_o, if_valid_o);
    end
    tick();
  endtask

  task automatic test_fetch_only();
    for (int k = 0; k < 4; k++) begin
      if (k < 3) begin if_req = 1'b1; if_addr = k; end else if_req = 1'b0;
      #1;
      if (k < 3) begin
        n_tests++;
        if (if_grant_o !== 1'b1 || stall_if_o !== 1'b0 || mem_addr_o !== ADDR_W'(k)) begin
          n_fail++;
          $display("FAIL fetch_grant[%0d]: got grant=%b stall=%b addr=%h expected 1 0 %h", k, if_grant_o, stall_if_o, mem_addr_o, k);
        end
      end
      if (k >= 1) begin
        n_tests++;
        if (if_valid_o !== 1'b1 || if_rdata_o !== 32'h100 + k - 1) begin
          n_fail++;
          $display("FAIL fetch_data[%0d]: got valid=%b rdata=%h expected 1 %h", k, if_valid_o, if_rdata_o, 32'h100 + k - 1);
        end
      end
      tick();
    end
  endtask

  task automatic test_load_store();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'd8; d_wdata = 32'hDEADBEEF; #1;
    n_tests++;
    if ({d_grant_o, mem_we_o} !== 2'b11 || mem_addr_o !== 32'd8 || mem_wdata_o !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL store_port: got grant/we=%b addr=%h wdata=%h expected 11 8 deadbeef", {d_grant_o, mem_we_o}, mem_addr_o, mem_wdata_o);
    end
    tick(); d_we = 1'b0; #1;
    n_tests++;
    if ({d_grant_o, mem_we_o, d_valid_o} !== 3'b100) begin
      n_fail++;
      $display("FAIL load_issue: got grant/we/valid=%b expected 100", {d_grant_o, mem_we_o, d_valid_o});
    end
    tick(); d_req = 1'b0; #1;
    n_tests++;
    if (d_valid_o !== 1'b1 || d_rdata_o !== 32'hDEADBEEF || mem_we_o !== 1'b0) begin
      n_fail++;
      $display("FAIL load_return: got valid=%b rdata=%h we=%b expected 1 deadbeef 0", d_valid_o, d_rdata_o, mem_we_o);
    end
    tick(); #1;
    n_tests++;
    if (d_valid_o !== 1'b0 || d_rdata_o !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL load_hold: got valid=%b rdata=%h expected 0 deadbeef", d_valid_o, d_rdata_o);
    end
    tick();
  endtask

  task automatic test_conflict();
    logic exp_d, prev_d;
    for (int c = 0; c <= 10; c++) begin
      if (c < 10) begin
        if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; if_addr = 32'd4; d_addr = 32'd6;
      end else idle_inputs();
      #1;
      if (c < 10) begin
        exp_d = (c % (MAX_WAIT + 1)) != MAX_WAIT;
        n_tests++;
        if ({d_grant_o, if_grant_o, stall_if_o, stall_mem_o} !== {exp_d, !exp_d, exp_d, !exp_d}
            || wait_cnt_o !== 4'(c % (MAX_WAIT + 1))) begin
          n_fail++;
          $display("FAIL conflict[%0d]: got dg/ig/sif/smem=%b wait=%0d expected %b wait=%0d", c,
                   {d_grant_o, if_grant_o, stall_if_o, stall_mem_o}, wait_cnt_o,
                   {exp_d, !exp_d, exp_d, !exp_d}, c % (MAX_WAIT + 1));
        end
      end
      if (c >= 1) begin
        prev_d = ((c - 1) % (MAX_WAIT + 1)) != MAX_WAIT;
        n_tests++;
        if ({if_valid_o, d_valid_o} !== {!prev_d, prev_d}
            || (prev_d ? d_rdata_o : if_rdata_o) !== (prev_d ? 32'h106 : 32'h104)) begin
          n_fail++;
          $display("FAIL conflict_resp[%0d]: got iv/dv=%b if_rdata=%h d_rdata=%h expected %b", c,
                   {if_valid_o, d_valid_o}, if_rdata_o, d_rdata_o, {!prev_d, prev_d});
        end
      end
      tick();
    end
  endtask

  task automatic test_hold();
    if_req = 1'b1; if_addr = 32'd5; #1;
    n_tests++;
    if (if_grant_o !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_grant: got %b expected 1", if_grant_o);
    end
    tick(); if_req = 1'b0; #1;
    n_tests++;
    if (if_valid_o !== 1'b1 || if_rdata_o !== 32'h105) begin
      n_fail++;
      $display("FAIL hold_pulse: got valid=%b rdata=%h expected 1 105", if_valid_o, if_rdata_o);
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      #1;
      n_tests++;
      if (if_valid_o !== 1'b0 || if_rdata_o !== 32'h105 || state_o !== 2'd0) begin
        n_fail++;
        $display("FAIL hold_idle[%0d]: got valid=%b rdata=%h state=%0d expected 0 105 0", k, if_valid_o, if_rdata_o, state_o);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_read();
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; if_addr = 32'd2; d_addr = 32'd8; #1;
    n_tests++;
    if (d_grant_o !== 1'b1 || wait_cnt_o !== 4'd0) begin
      n_fail++;
      $display("FAIL midrst_pre: got grant=%b wait=%0d expected 1 0", d_grant_o, wait_cnt_o);
    end
    tick(); #1;
    n_tests++;
    if (d_grant_o !== 1'b1 || wait_cnt_o !== 4'd1) begin
      n_fail++;
      $display("FAIL midrst_grant: got grant=%b wait=%0d expected 1 1", d_grant_o, wait_cnt_o);
    end
    #1 rst_ni = 1'b0; #1;
    n_tests++;
    if ({d_grant_o, if_grant_o, stall_if_o, stall_mem_o} !== 4'b0011) begin
      n_fail++;
      $display("FAIL midrst_gate: got %b expected 0011", {d_grant_o, if_grant_o, stall_if_o, stall_mem_o});
    end
    tick(); #1;
    n_tests++;
    if ({d_valid_o, if_valid_o} !== 2'b00 || d_rdata_o !== '0 || if_rdata_o !== '0
        || wait_cnt_o !== 4'd0 || state_o !== 2'd0) begin
      n_fail++;
      $display("FAIL midrst_after: got dv/iv=%b d_rdata=%h if_rdata=%h wait=%0d state=%0d expected 00 0 0 0 0",
               {d_valid_o, if_valid_o}, d_rdata_o, if_rdata_o, wait_cnt_o, state_o);
    end
    rst_ni = 1'b1; idle_inputs();
    tick(); #1;
    n_tests++;
    if ({d_valid_o, if_valid_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL midrst_novalid: got %b expected 00", {d_valid_o, if_valid_o});
    end
    tick();
  endtask

  // Randomized traffic scored against a rule-level model.
  task automatic test_random();
    logic [DATA_W-1:0] ref_mem [16];
    logic [DATA_W:0]   exp_q[$];     // {is_fetch, data} of the read returning next cycle
    logic [DATA_W:0]   e;
    logic [DATA_W-1:0] held_if, held_d, exp_wd;
    logic [ADDR_W-1:0] exp_addr;
    logic              eg_d, eg_if, exp_iv, exp_dv;
    int                denied;
    rst_ni = 1'b0; idle_inputs();
    tick();
    rst_ni = 1'b1;
    ref_mem = mem;
    held_if = '0; held_d = '0; denied = 0;
    for (int n = 0; n <= 300; n++) begin
      if (n < 300) begin
        if_req  = ($urandom_range(0, 3) != 0);
        d_req   = ($urandom_range(0, 3) != 0);
        d_we    = ($urandom_range(0, 2) == 0);
        if_addr = $urandom_range(0, 15);
        d_addr  = $urandom_range(0, 15);
        d_wdata = $urandom;
      end else idle_inputs();
      #1;
      eg_d     = d_req && !(if_req && denied == MAX_WAIT);
      eg_if    = if_req && !eg_d;
      exp_addr = eg_d ? d_addr : (eg_if ? if_addr : '0);
      exp_wd   = eg_d ? d_wdata : '0;
      n_tests++;
      if ({d_grant_o, if_grant_o, stall_if_o, stall_mem_o, mem_we_o} !==
          {eg_d, eg_if, if_req && !eg_if, d_req && !eg_d, eg_d && d_we} || wait_cnt_o !== 4'(denied)) begin
        n_fail++;
        $display("FAIL rand_ctl[%0d]: got dg/ig/sif/smem/we=%b wait=%0d expected %b wait=%0d", n,
                 {d_grant_o, if_grant_o, stall_if_o, stall_mem_o, mem_we_o}, wait_cnt_o,
                 {eg_d, eg_if, if_req && !eg_if, d_req && !eg_d, eg_d && d_we}, denied);
      end
      n_tests++;
      if (mem_addr_o !== exp_addr || mem_wdata_o !== exp_wd) begin
        n_fail++;
        $display("FAIL rand_port[%0d]: got addr=%h wdata=%h expected %h %h", n, mem_addr_o, mem_wdata_o, exp_addr, exp_wd);
      end
      exp_iv = 1'b0; exp_dv = 1'b0;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e[DATA_W]) begin exp_iv = 1'b1; held_if = e[DATA_W-1:0]; end
        else begin exp_dv = 1'b1; held_d = e[DATA_W-1:0]; end
      end
      n_tests++;
      if ({if_valid_o, d_valid_o} !== {exp_iv, exp_dv} || if_rdata_o !== held_if || d_rdata_o !== held_d) begin
        n_fail++;
        $display("FAIL rand_resp[%0d]: got iv/dv=%b if=%h d=%h expected %b if=%h d=%h", n,
                 {if_valid_o, d_valid_o}, if_rdata_o, d_rdata_o, {exp_iv, exp_dv}, held_if, held_d);
      end
      if (eg_if) exp_q.push_back({1'b1, ref_mem[if_addr[3:0]]});
      if (eg_d && !d_we) exp_q.push_back({1'b0, ref_mem[d_addr[3:0]]});
      if (eg_d && d_we) ref_mem[d_addr[3:0]] = d_wdata;
      if (if_req && !eg_if) denied = (denied < MAX_WAIT) ? denied + 1 : denied;
      else denied = 0;
      tick();
    end
  endtask

  initial begin
    idle_inputs();
    rst_ni = 1'b0;
    test_reset();
    test_fetch_only();
    test_load_store();
    test_conflict();
    test_hold();
    test_reset_mid_read();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
